// File: rtl/synth_scaler_pkg.sv
// Shared audio definitions for the synth gain/mute stage: widths, midscale
// code, window FSM states and a saturating counter helper.
package synth_scaler_pkg;

  localparam int IN_WIDTH   = 14;
  localparam int OUT_WIDTH  = IN_WIDTH - 4;
  localparam int GAIN_FRAC  = 3;
  localparam int GAIN_WIDTH = 4;
  localparam int PROD_WIDTH = IN_WIDTH + GAIN_WIDTH + 1;
  localparam int CNT_WIDTH  = 16;

  localparam logic [OUT_WIDTH-1:0] MIDSCALE = OUT_WIDTH'(512);

  typedef enum logic [1:0] {
    WIN_IDLE,
    WIN_OPEN,
    WIN_SERVED
  } winState_e;

  // Debug counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] value);
    return (value == {CNT_WIDTH{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/synth_scaler_conv.sv
// Shift, saturate and offset-binary conversion of a gained product.
// Shifting by the gain fraction and the dropped LSBs in one step leaves the
// output field in the low bits; the bits above it must all match the sign,
// otherwise the 14-bit range was exceeded and the code is clamped.
module sat_offset_conv
  import synth_scaler_pkg::*;
(
  input  logic signed [PROD_WIDTH-1:0] prod_i,
  output logic        [OUT_WIDTH-1:0]  code_o,
  output logic                         clip_o
);

  localparam int DROP = GAIN_FRAC + (IN_WIDTH - OUT_WIDTH);

  logic signed [PROD_WIDTH-1:0]       shifted;
  logic        [PROD_WIDTH-OUT_WIDTH:0] headBits;

  // Clamp to full scale when the scaled value leaves the 14-bit range.
  always_comb begin
    shifted  = prod_i >>> DROP;
    headBits = shifted[PROD_WIDTH-1:OUT_WIDTH-1];
    clip_o   = !((&headBits) || (~|headBits));
    if (clip_o) begin
      code_o = shifted[PROD_WIDTH-1] ? {OUT_WIDTH{1'b0}} : {OUT_WIDTH{1'b1}};
    end else begin
      code_o = {~shifted[OUT_WIDTH-1], shifted[OUT_WIDTH-2:0]};
    end
  end

endmodule

// File: rtl/synth_scaler.sv
// Gain/mute stage feeding the sampler: two-stage elastic pipeline, output
// paced to the sampler's ready window, clip and underrun debug counters.
module synth_scaler
  import synth_scaler_pkg::*;
#(
  parameter bit ONE_PER_WINDOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  input  logic signed [IN_WIDTH-1:0]  in_sample_i,
  output logic                        in_ready_o,
  input  logic        [GAIN_WIDTH-1:0] gain_i,
  input  logic                        mute_i,
  output logic                        out_valid_o,
  output logic        [OUT_WIDTH-1:0] out_code_o,
  input  logic                        out_ready_i,
  output logic        [CNT_WIDTH-1:0] sat_count_o,
  output logic        [CNT_WIDTH-1:0] underrun_count_o
);

  logic                         s1Valid_q, s1Valid_d;
  logic signed [PROD_WIDTH-1:0] s1Prod_q, s1Prod_d;
  logic                         s1Mute_q, s1Mute_d;
  logic                         s2Valid_q, s2Valid_d;
  logic [OUT_WIDTH-1:0]         s2Code_q, s2Code_d;
  logic [CNT_WIDTH-1:0]         satCount_q, satCount_d;
  logic [CNT_WIDTH-1:0]         underrunCount_q;
  logic                         readyDly_q;
  winState_e                    state_q;

  logic signed [PROD_WIDTH-1:0] inProd;
  logic [OUT_WIDTH-1:0]         convCode;
  logic                         convClip;
  logic                         outValid;
  logic                         outXfer;
  logic                         inXfer;
  logic                         s1Advance;
  logic                         readyRise;
  logic                         readyFall;

  sat_offset_conv uConv (
    .prod_i (s1Prod_q),
    .code_o (convCode),
    .clip_o (convClip)
  );

  // Handshake terms; the window gate only holds the output back, S2 keeps its data.
  always_comb begin
    inProd    = $signed(in_sample_i) * $signed({1'b0, gain_i});
    outValid  = s2Valid_q && (!ONE_PER_WINDOW || (state_q != WIN_SERVED));
    outXfer   = outValid && out_ready_i;
    s1Advance = s1Valid_q && (!s2Valid_q || outXfer);
    in_ready_o = !s1Valid_q || s1Advance;
    inXfer    = in_valid_i && in_ready_o;
    readyRise = out_ready_i && !readyDly_q;
    readyFall = !out_ready_i && readyDly_q;
  end

  // Next state of both pipeline stages and the clip counter.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Prod_d   = s1Prod_q;
    s1Mute_d   = s1Mute_q;
    s2Valid_d  = s2Valid_q;
    s2Code_d   = s2Code_q;
    satCount_d = satCount_q;
    if (inXfer) begin
      s1Valid_d = 1'b1;
      s1Prod_d  = inProd;
      s1Mute_d  = mute_i;
    end else if (s1Advance) begin
      s1Valid_d = 1'b0;
    end
    if (s1Advance) begin
      s2Valid_d = 1'b1;
      s2Code_d  = s1Mute_q ? MIDSCALE : convCode;
      if (!s1Mute_q && convClip) begin
        satCount_d = satInc(satCount_q);
      end
    end else if (outXfer) begin
      s2Valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset empties both stages and parks the code at midscale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Prod_q   <= '0;
      s1Mute_q   <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Code_q   <= MIDSCALE;
      satCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Prod_q   <= s1Prod_d;
      s1Mute_q   <= s1Mute_d;
      s2Valid_q  <= s2Valid_d;
      s2Code_q   <= s2Code_d;
      satCount_q <= satCount_d;
    end
  end

  // Window tracker: one window spans an out_ready rise to its fall; an unserved window is an underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WIN_IDLE;
      readyDly_q      <= 1'b0;
      underrunCount_q <= '0;
    end else begin
      readyDly_q <= out_ready_i;
      case (state_q)
        WIN_IDLE: begin
          if (readyRise) begin
            state_q <= outXfer ? WIN_SERVED : WIN_OPEN;
          end
        end
        WIN_OPEN: begin
          if (outXfer) begin
            state_q <= WIN_SERVED;
          end else if (readyFall) begin
            state_q         <= WIN_IDLE;
            underrunCount_q <= satInc(underrunCount_q);
          end
        end
        WIN_SERVED: begin
          if (readyFall) begin
            state_q <= WIN_IDLE;
          end
        end
        default: state_q <= WIN_IDLE;
      endcase
    end
  end

  assign out_valid_o      = outValid;
  assign out_code_o       = s2Code_q;
  assign sat_count_o      = satCount_q;
  assign underrun_count_o = underrunCount_q;

endmodule

// File: tb/tb_synth_scaler.sv
// Scoreboard bench for synth_scaler: stimulus pushes hand-computed codes,
// an independent monitor pops and compares on every output transfer.
module tb_synth_scaler;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic signed [13:0] in_sample;
  logic               in_ready;
  logic [3:0]         gain;
  logic               mute;
  logic               out_valid;
  logic [9:0]         out_code;
  logic               out_ready;
  logic [15:0]        sat_count;
  logic [15:0]        underrun_count;

  int checksTotal  = 0;
  int checksPassed = 0;
  int xferCount    = 0;
  logic [9:0] expQ[$];

  synth_scaler #(.ONE_PER_WINDOW(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid),
    .in_sample_i      (in_sample),
    .in_ready_o       (in_ready),
    .gain_i           (gain),
    .mute_i           (mute),
    .out_valid_o      (out_valid),
    .out_code_o       (out_code),
    .out_ready_i      (out_ready),
    .sat_count_o      (sat_count),
    .underrun_count_o (underrun_count)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck handshake never hangs the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offer one sample; the expected code is queued once the stage takes it.
  task automatic applyStimulus(input logic signed [13:0] sample, input logic [3:0] g,
                               input logic m, input logic [9:0] expCode);
    bit accepted;
    accepted  = 1'b0;
    in_sample = sample;
    gain      = g;
    mute      = m;
    in_valid  = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    mute     = 1'b0;
    if (accepted) begin
      expQ.push_back(expCode);
    end else begin
      checksTotal++;
      $display("[TB] FAIL acceptTimeout: sample %0d not accepted in 50 cycles, required acceptance", sample);
    end
  endtask

  // Raise out_ready for n cycles, then let the fall be seen.
  task automatic openWindow(input int n);
    out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      xferCount++;
      if (expQ.size() == 0) begin
        checksTotal++;
        $display("[TB] FAIL outCode: unexpected transfer of %0d, required no transfer", out_code);
      end else begin
        checkOutput("outCode", out_code, expQ.pop_front());
      end
    end
  end

  initial begin
    int  startX;
    bit  servedSeen;
    bit  gateViolation;
    bit  sawReady;
    bit  pendingAccept;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    gain      = 4'd8;
    mute      = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #13;
    checkOutput("resetOutValid", out_valid, 0);
    checkOutput("resetOutCode", out_code, 512);
    checkOutput("resetSatCount", sat_count, 0);
    checkOutput("resetUnderrun", underrun_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetInReady", in_ready, 1);
    @(posedge clk);
    #1;

    // Unity gain, with latency check on the first sample
    applyStimulus(14'sd8191, 4'd8, 1'b0, 10'd1023);
    @(negedge clk);
    checkOutput("latencyEarly", out_valid, 0);
    @(negedge clk);
    checkOutput("latencyDue", out_valid, 1);
    @(posedge clk);
    #1;
    openWindow(3);
    applyStimulus(14'sd0, 4'd8, 1'b0, 10'd512);
    openWindow(3);
    applyStimulus(-14'sd8192, 4'd8, 1'b0, 10'd0);
    openWindow(3);
    applyStimulus(14'sd6000, 4'd8, 1'b0, 10'd887);
    openWindow(3);
    checkOutput("unitySatCount", sat_count, 0);

    // Clipping
    applyStimulus(14'sd6000, 4'd15, 1'b0, 10'd1023);
    openWindow(3);
    checkOutput("clipPosSatCount", sat_count, 1);
    applyStimulus(-14'sd6000, 4'd15, 1'b0, 10'd0);
    openWindow(3);
    checkOutput("clipNegSatCount", sat_count, 2);

    // Mute
    applyStimulus(14'sd8191, 4'd15, 1'b1, 10'd512);
    openWindow(3);
    checkOutput("muteSatCount", sat_count, 2);

    // Backpressure then one transfer per long window
    applyStimulus(14'sd1600, 4'd8, 1'b0, 10'd612);
    applyStimulus(-14'sd1600, 4'd8, 1'b0, 10'd412);
    in_sample = 14'sd3200;
    gain      = 4'd8;
    in_valid  = 1'b1;
    sawReady  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (in_ready) sawReady = 1'b1;
    end
    checkOutput("fullInReady", sawReady, 0);
    @(posedge clk);
    #1;
    startX        = xferCount;
    servedSeen    = 1'b0;
    gateViolation = 1'b0;
    out_ready     = 1'b1;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      #1;
      if (servedSeen && out_valid) gateViolation = 1'b1;
      if (xferCount - startX >= 1) servedSeen = 1'b1;
      pendingAccept = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (pendingAccept) begin
        in_valid = 1'b0;
        expQ.push_back(10'd712);
      end
    end
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("windowXfers", xferCount - startX, 1);
    checkOutput("gatedAfterServe", gateViolation, 0);
    checkOutput("thirdAccepted", in_valid, 0);
    checkOutput("refullInReady", in_ready, 0);
    checkOutput("servedNoUnderrun", underrun_count, 0);
    openWindow(3);
    openWindow(3);

    // Underrun windows: a long empty one, then a one-cycle one
    openWindow(101);
    checkOutput("underrunLong", underrun_count, 1);
    openWindow(1);
    checkOutput("underrunShort", underrun_count, 2);

    // Reset with a full pipeline
    applyStimulus(14'sd400, 4'd8, 1'b0, 10'd537);
    applyStimulus(-14'sd400, 4'd8, 1'b0, 10'd487);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midResetOutValid", out_valid, 0);
    checkOutput("midResetOutCode", out_code, 512);
    checkOutput("midResetSatCount", sat_count, 0);
    checkOutput("midResetUnderrun", underrun_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postResetInReady", in_ready, 1);
    checkOutput("postResetOutValid", out_valid, 0);
    @(posedge clk);
    #1;
    startX = xferCount;
    applyStimulus(14'sd800, 4'd8, 1'b0, 10'd562);
    openWindow(3);
    checkOutput("postResetXfers", xferCount - startX, 1);
    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/synth_scaler.md
# synth_scaler

Gain/mute stage directly upstream of `sampler`. Accepts signed 14-bit synth samples over a valid/ready handshake and applies a 4-bit gain. It saturates the result and converts it to the 10-bit offset-binary `scaled_synth_code` that `sampler` consumes. It paces output to `sampler`'s periodic `synth_ready` window and counts clipped samples and missed windows for debug.

## Interface
- `IN_WIDTH`, 14: signed input sample width.
- `OUT_WIDTH`, 10: unsigned output code width (`IN_WIDTH-4`).
- `GAIN_FRAC`, 3: fractional bits of gain; gain 8 = unity.
- `ONE_PER_WINDOW`, 1: when 1, at most one output transfer per `out_ready` window.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input sample valid.
- `in_sample`  in  14  signed two's-complement sample.
- `in_ready`  out  1  stage can accept a sample.
- `gain`  in  4  unsigned gain, 0..15; value = gain/8.
- `mute`  in  1  force midscale output.
- `out_valid`  out  1  `out_code` valid; drives `sampler.synth_valid`.
- `out_code`  out  10  offset-binary code; drives `sampler.scaled_synth_code`.
- `out_ready`  in  1  from `sampler.synth_ready`.
- `sat_count`  out  16  samples clipped since reset; saturates at 0xFFFF.
- `underrun_count`  out  16  windows closed without a transfer; saturates at 0xFFFF.

## Operation
- **Two-stage elastic pipeline.**
  - S1 registers the sample and the product `in_sample*gain` (19-bit signed). `gain` and `mute` are sampled at acceptance.
  - S2 computes `p >>> GAIN_FRAC` (arithmetic), saturates to [-8192, 8191] and takes bits [13:4]. It inverts the MSB to produce offset binary. If `mute` was captured, S2 outputs 512. S2 is the output register.
- **Clip counting:** `sat_count` increments when a sample enters S2 and saturation changed its value. Muted samples never count.
- **Transfers:**
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
  - `in_ready = !s1_valid || s1_advance`.
  - `s1_advance = s1_valid && (!s2_valid || out_xfer)`.
  - Pipeline capacity is 2 samples.
- **Window FSM:** states IDLE, OPEN, SERVED; `ready_q` is `out_ready` delayed by one cycle.
  - IDLE -> OPEN on a rising edge of `out_ready`.
  - OPEN -> SERVED on an output transfer.
  - OPEN -> IDLE when `out_ready` falls; `underrun_count` increments.
  - SERVED -> IDLE when `out_ready` falls.
  - A rising edge and a transfer in the same cycle go IDLE -> SERVED.
- **Output gating:** `out_valid = s2_valid && (ONE_PER_WINDOW==0 || state != SERVED)`. S2 holds its data while gated.
- **Reset** (async assert, sync release): pipeline empty, FSM IDLE, both counters 0.
  - Reset mid-operation discards all in-flight samples.

## Timing
- Output reset values: `out_valid`=0, `out_code`=512, `sat_count`=0, `underrun_count`=0. `in_ready`=1 once reset is released.
- Latency: 2 cycles from input transfer to `out_valid` with an empty pipeline and no gating.
- `out_code` and `out_valid` are registered or depend only on registered state. `in_ready` is combinational from `out_ready`.
- `out_code` is stable while `out_valid && !out_ready`.
- Simultaneous input and output transfer with a full pipeline: both occur; occupancy is unchanged.
- An `out_ready` rise and fall one cycle apart is still one window.
- Counters saturate at 0xFFFF and never wrap.

## Structure
- Shared audio package holds `IN_WIDTH`, `OUT_WIDTH`, `GAIN_FRAC`, the midscale constant 512 and the FSM state enum.
- One natural sub-module is `sat_offset_conv`: combinational shift, saturate and offset-binary conversion, with a clip flag output.
- The window FSM and counters stay in the top module.

## Test plan
- **Unity gain:** gain=8, samples 8191 / 0 / -8192 / 6000, one per window -> codes 1023 / 512 / 0 / 887; `sat_count`=0.
- **Clipping:** gain=15, sample 6000 (product/8 = 11250) -> code 1023; `sat_count`=1. Same with -6000 -> code 0; `sat_count`=2.
- **Mute:** mute=1, gain=15, sample 8191 -> code 512; `sat_count` unchanged.
- **One per window:** ONE_PER_WINDOW=1, 3 samples queued, `out_ready` high 101 cycles -> exactly 1 transfer; `out_valid` low for the rest of the window.
- **Underrun and backpressure:** a 101-cycle window with no input -> `underrun_count`=1 after the fall. With `out_ready` low, offer 3 samples -> 2 accepted and `in_ready`=0 until a transfer.
- **Reset mid-operation:** assert `rst_n`=0 with a full pipeline -> `out_valid`=0 and `out_code`=512 immediately; counters 0; `in_ready`=1 after release.
